instr_issue_unit: RTL

- Instruction fetch/issue sequencer that drives the opcode decoder.
- Reads 16-bit instructions from instruction memory over a req/ack handshake and splits each into opcode and operand fields.
- Presents each instruction to the decode stage over a valid/ready handshake.
- Inserts a one-cycle bubble on a load-use hazard.

---
 rtl/instr_issue_unit_if.sv | 29 ++
 rtl/instr_issue_unit.sv | 129 ++++++++++++
 2 files changed

// File: rtl/instr_issue_unit_if.sv
// Handshake bundle between the issue sequencer, instruction memory and decode stage.
// The sequencer side is the master; memory/decode/control side is the slave.
interface instr_issue_unit_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [15:0]       imem_rdata;
  logic              issue_valid;
  logic              issue_ready;
  logic [2:0]        opco;
  logic [2:0]        rd;
  logic [2:0]        rs;
  logic [6:0]        imm;
  logic              stall;
  logic              done;

  modport master (
    input  start, imem_ack, imem_rdata, issue_ready,
    output imem_req, imem_addr, issue_valid, opco, rd, rs, imm, stall, done
  );

  modport slave (
    output start, imem_ack, imem_rdata, issue_ready,
    input  imem_req, imem_addr, issue_valid, opco, rd, rs, imm, stall, done
  );
endinterface

// File: rtl/instr_issue_unit.sv
// Fetch/issue sequencer: fetches PROG_LEN 16-bit instructions over req/ack and
// presents them to the decoder over valid/ready, with a one-cycle load-use bubble.
module instr_issue_unit #(
  parameter int ADDR_W   = 8,
  parameter int PROG_LEN = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  instr_issue_unit_if.master   bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    BUBBLE = 3'd2,
    ISSUE  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] LEN_C    = (ADDR_W+1)'(PROG_LEN);
  localparam logic            LEN_ZERO = (PROG_LEN == 32'sd0);
  localparam logic [2:0]      OP_LW    = 3'b110;

  state_t            state_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W:0]   count_r;
  logic [15:0]       ir_r;
  logic              last_lw_r;
  logic [2:0]        last_rd_r;
  logic              imem_req_r;
  logic              issue_valid_r;
  logic              stall_r;
  logic              done_r;

  logic              hazard_s;
  logic [ADDR_W:0]   count_inc_s;

  // A fetched word that reads the register just loaded must wait one cycle.
  assign hazard_s    = last_lw_r && (bus.imem_rdata[9:7] == last_rd_r);
  assign count_inc_s = count_r + (ADDR_W+1)'(1'b1);

  assign bus.imem_req    = imem_req_r;
  assign bus.imem_addr   = pc_r;
  assign bus.issue_valid = issue_valid_r;
  assign bus.opco        = ir_r[15:13];
  assign bus.rd          = ir_r[12:10];
  assign bus.rs          = ir_r[9:7];
  assign bus.imm         = ir_r[6:0];
  assign bus.stall       = stall_r;
  assign bus.done        = done_r;

  // Sequencer state machine with registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      pc_r          <= {ADDR_W{1'b0}};
      count_r       <= {(ADDR_W+1){1'b0}};
      ir_r          <= 16'h0000;
      last_lw_r     <= 1'b0;
      last_rd_r     <= 3'd0;
      imem_req_r    <= 1'b0;
      issue_valid_r <= 1'b0;
      stall_r       <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            pc_r      <= {ADDR_W{1'b0}};
            count_r   <= {(ADDR_W+1){1'b0}};
            last_lw_r <= 1'b0;
            last_rd_r <= 3'd0;
            if (LEN_ZERO) begin
              state_r    <= DONE;
              done_r     <= 1'b1;
              imem_req_r <= 1'b0;
            end else begin
              state_r    <= FETCH;
              done_r     <= 1'b0;
              imem_req_r <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (bus.imem_ack) begin
            ir_r       <= bus.imem_rdata;
            pc_r       <= pc_r + ADDR_W'(1'b1);
            imem_req_r <= 1'b0;
            if (hazard_s) begin
              state_r <= BUBBLE;
              stall_r <= 1'b1;
            end else begin
              state_r       <= ISSUE;
              issue_valid_r <= 1'b1;
            end
          end
        end
        BUBBLE: begin
          stall_r       <= 1'b0;
          issue_valid_r <= 1'b1;
          state_r       <= ISSUE;
        end
        ISSUE: begin
          if (bus.issue_ready) begin
            issue_valid_r <= 1'b0;
            last_lw_r     <= (ir_r[15:13] == OP_LW);
            last_rd_r     <= ir_r[12:10];
            count_r       <= count_inc_s;
            if (count_inc_s == LEN_C) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r    <= FETCH;
              imem_req_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r       <= IDLE;
          imem_req_r    <= 1'b0;
          issue_valid_r <= 1'b0;
          stall_r       <= 1'b0;
          done_r        <= 1'b0;
        end
      endcase
    end
  end

endmodule
